// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the oversampling SPI peripheral
package spi_pkg;

  typedef enum logic {SPI_IDLE, SPI_ACTIVE} spi_state_t;

  localparam int unsigned SPI_MIN_SYNC_STAGES = 2;

  // Sample edge is the rising SCK edge for modes 0 and 3, falling for modes 1 and 2.
  function automatic logic spi_sample_on_rise(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_peripheral_sync_if.sv
// rtl/spi_peripheral_sync_if.sv - word-side TX/RX handshake bundle of the SPI peripheral
interface spi_peripheral_sync_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  // Command decoder side: offers TX words, consumes RX words.
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  // Peripheral side.
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - N-stage pin synchroniser with rise/fall edge detection
module spi_pin_sync
  import spi_pkg::*;
#(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // Never fewer than the minimum metastability depth, whatever the caller asks.
  localparam int unsigned N = (STAGES < SPI_MIN_SYNC_STAGES) ? SPI_MIN_SYNC_STAGES : STAGES;

  logic [N-1:0] sync_q;
  logic         last_q;

  // Shift the pin through the chain; last_q holds the previous synchronised level.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= {N{RESET_VAL}};
      last_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[N-2:0], pin_i};
      last_q <= sync_q[N-1];
    end
  end

  assign level_o = sync_q[N-1];
  assign rise_o  = sync_q[N-1] & ~last_q;
  assign fall_o  = ~sync_q[N-1] & last_q;

endmodule

// File: rtl/spi_peripheral_sync.sv
// rtl/spi_peripheral_sync.sv - SPI peripheral that oversamples the pins in the system clock domain
module spi_peripheral_sync
  import spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter bit                    CPOL        = 1'b0,
  parameter bit                    CPHA        = 1'b0,
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_FILL     = '1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  spi_cs_ni,
  input  logic                  spi_sck_i,
  input  logic                  spi_sd_i,
  output logic                  spi_sd_o,
  output logic                  spi_sd_oe_o,
  spi_peripheral_sync_if.slave  bus,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  underrun_o
);

  localparam int unsigned          CNT_W       = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT    = CNT_W'(DATA_WIDTH - 1);
  localparam logic                 SAMPLE_RISE = spi_sample_on_rise(CPOL, CPHA);

  logic cs_rise, cs_fall, cs_level_unused;
  logic sck_rise, sck_fall, sck_level_unused;
  logic sdi, sdi_rise_unused, sdi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i(clk_i), .reset_ni(reset_ni), .pin_i(spi_cs_ni),
    .level_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sck_sync (
    .clk_i(clk_i), .reset_ni(reset_ni), .pin_i(spi_sck_i),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi_sync (
    .clk_i(clk_i), .reset_ni(reset_ni), .pin_i(spi_sd_i),
    .level_o(sdi), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
  );

  spi_state_t            state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d, hold_q;
  logic                  hold_full_q, first_shift_q;
  logic                  rx_valid_q, start_q, stop_q, underrun_q;

  logic active, sample_edge, shift_edge, start_load, shift_load, load, tx_bit;

  assign active      = (state_q == SPI_ACTIVE);
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

  // CPHA=0 must present bit 0 before the first SCK edge, so it loads at CS fall;
  // the first shift edge of such a frame is skipped as a load point.
  assign start_load  = (state_q == SPI_IDLE) && cs_fall && (CPHA == 1'b0);
  assign shift_load  = active && !cs_rise && shift_edge && (bit_cnt_q == '0)
                       && ((CPHA == 1'b1) || !first_shift_q);
  assign load        = start_load || shift_load;

  assign rx_shift_d  = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], sdi}
                                 : {sdi, rx_shift_q[DATA_WIDTH-1:1]};
  assign tx_shift_d  = MSB_FIRST ? {tx_shift_q[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
  assign tx_bit      = MSB_FIRST ? tx_shift_q[DATA_WIDTH-1] : tx_shift_q[0];

  // Frame FSM, bit engine and TX holding register with registered strobes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= SPI_IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      first_shift_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      case (state_q)
        SPI_IDLE: begin
          if (cs_fall) begin
            state_q       <= SPI_ACTIVE;
            start_q       <= 1'b1;
            underrun_q    <= 1'b0;
            first_shift_q <= 1'b1;
            bit_cnt_q     <= '0;
          end
        end
        SPI_ACTIVE: begin
          if (cs_rise) begin
            // Partial words are dropped; the holding register is left alone.
            state_q    <= SPI_IDLE;
            stop_q     <= 1'b1;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
          end else begin
            if (sample_edge) begin
              rx_shift_q <= rx_shift_d;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q  <= '0;
                rx_data_q  <= rx_shift_d;
                rx_valid_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            if (shift_edge) begin
              first_shift_q <= 1'b0;
              if (!shift_load) tx_shift_q <= tx_shift_d;
            end
          end
        end
        default: state_q <= SPI_IDLE;
      endcase

      // Load priority: held word, then a bypassed fresh word, then the fill pattern.
      if (load) begin
        if (hold_full_q) begin
          tx_shift_q  <= hold_q;
          hold_full_q <= 1'b0;
        end else if (bus.tx_valid) begin
          tx_shift_q <= bus.tx_data;
        end else begin
          tx_shift_q <= TX_FILL;
          underrun_q <= 1'b1;
        end
      end else if (bus.tx_valid && !hold_full_q) begin
        hold_q      <= bus.tx_data;
        hold_full_q <= 1'b1;
      end
    end
  end

  assign bus.tx_ready = !hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign spi_sd_o     = active & tx_bit;
  assign spi_sd_oe_o  = active;
  assign start_o      = start_q;
  assign stop_o       = stop_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_spi_peripheral_sync.sv
// tb/tb_spi_peripheral_sync.sv - directed bench for spi_peripheral_sync in modes 0, 1 and 3
module tb_spi_peripheral_sync;

  localparam int HALF = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       sck, sdi;
  logic [2:0] cs_n;
  logic       sd0, oe0, st0, sp0, ur0;
  logic       sd1, oe1, st1, sp1, ur1;
  logic       sd2, oe2, st2, sp2, ur2;
  logic       miso_pin;

  spi_peripheral_sync_if #(.DATA_WIDTH(8))  bus0 ();
  spi_peripheral_sync_if #(.DATA_WIDTH(16)) bus1 ();
  spi_peripheral_sync_if #(.DATA_WIDTH(8))  bus2 ();

  spi_peripheral_sync #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m0 (
    .clk_i(clk), .reset_ni(reset_n), .spi_cs_ni(cs_n[0]), .spi_sck_i(sck), .spi_sd_i(sdi),
    .spi_sd_o(sd0), .spi_sd_oe_o(oe0), .bus(bus0), .start_o(st0), .stop_o(sp0), .underrun_o(ur0));

  spi_peripheral_sync #(.DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_m1 (
    .clk_i(clk), .reset_ni(reset_n), .spi_cs_ni(cs_n[1]), .spi_sck_i(sck), .spi_sd_i(sdi),
    .spi_sd_o(sd1), .spi_sd_oe_o(oe1), .bus(bus1), .start_o(st1), .stop_o(sp1), .underrun_o(ur1));

  spi_peripheral_sync #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_m3 (
    .clk_i(clk), .reset_ni(reset_n), .spi_cs_ni(cs_n[2]), .spi_sck_i(sck), .spi_sd_i(sdi),
    .spi_sd_o(sd2), .spi_sd_oe_o(oe2), .bus(bus2), .start_o(st2), .stop_o(sp2), .underrun_o(ur2));

  // Host-side configuration of the currently addressed peripheral.
  int sel = 0;
  bit h_cpol, h_cpha, h_msbf;
  int h_w;
  assign miso_pin = (sel == 0) ? sd0 : (sel == 1) ? sd1 : sd2;

  // TX word feeders: main process appends, feeder process consumes on handshake.
  logic [15:0] txbuf [3][16];
  int          tx_wr [3] = '{0, 0, 0};
  int          tx_rd [3] = '{0, 0, 0};
  logic [2:0]  tv;
  logic [15:0] td [3];
  logic [2:0]  rdy;

  assign rdy = {bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};
  assign bus0.tx_valid = tv[0];
  assign bus0.tx_data  = td[0][7:0];
  assign bus1.tx_valid = tv[1];
  assign bus1.tx_data  = td[1];
  assign bus2.tx_valid = tv[2];
  assign bus2.tx_data  = td[2][7:0];

  // Present queued words on negedge; ready is stable until the next posedge.
  initial begin
    tv = '0;
    for (int d = 0; d < 3; d++) td[d] = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (tx_rd[d] < tx_wr[d]) begin
          tv[d] = 1'b1;
          td[d] = txbuf[d][tx_rd[d]];
          if (rdy[d] && reset_n) tx_rd[d]++;
        end else begin
          tv[d] = 1'b0;
        end
      end
    end
  end

  // Strobe counters and last received word per peripheral.
  int          rxc [3] = '{0, 0, 0};
  int          stc [3] = '{0, 0, 0};
  int          spc [3] = '{0, 0, 0};
  logic [15:0] rxd [3] = '{16'h0, 16'h0, 16'h0};

  // Count one-cycle strobes, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus0.rx_valid) begin rxc[0] <= rxc[0] + 1; rxd[0] <= {8'h0, bus0.rx_data}; end
    if (bus1.rx_valid) begin rxc[1] <= rxc[1] + 1; rxd[1] <= bus1.rx_data; end
    if (bus2.rx_valid) begin rxc[2] <= rxc[2] + 1; rxd[2] <= {8'h0, bus2.rx_data}; end
    if (st0) stc[0] <= stc[0] + 1;
    if (st1) stc[1] <= stc[1] + 1;
    if (st2) stc[2] <= stc[2] + 1;
    if (sp0) spc[0] <= spc[0] + 1;
    if (sp1) spc[1] <= spc[1] + 1;
    if (sp2) spc[2] <= spc[2] + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int d, input logic [15:0] v);
    txbuf[d][tx_wr[d]] = v;
    tx_wr[d]++;
  endtask

  task automatic use_dut(input int d);
    sel = d;
    case (d)
      0:       begin h_cpol = 0; h_cpha = 0; h_msbf = 1; h_w = 8;  end
      1:       begin h_cpol = 0; h_cpha = 1; h_msbf = 0; h_w = 16; end
      default: begin h_cpol = 1; h_cpha = 1; h_msbf = 1; h_w = 8;  end
    endcase
    sck = h_cpol;
    clk_wait(10);
  endtask

  task automatic cs_assert();
    cs_n[sel] = 1'b0;
    clk_wait(8);
  endtask

  task automatic cs_release();
    clk_wait(HALF);
    cs_n[sel] = 1'b1;
    clk_wait(12);
  endtask

  task automatic xfer(input logic [15:0] mosi, input int nbits, output logic [15:0] miso);
    int idx;
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = h_msbf ? (h_w - 1 - i) : i;
      if (!h_cpha) begin
        sdi = mosi[idx];
        clk_wait(HALF);
        miso[idx] = miso_pin;
        sck = ~h_cpol;
        clk_wait(HALF);
        sck = h_cpol;
      end else begin
        sck = ~h_cpol;
        sdi = mosi[idx];
        clk_wait(HALF);
        miso[idx] = miso_pin;
        sck = h_cpol;
        clk_wait(HALF);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [15:0] m;
  int b_rx, b_st, b_sp;

  initial begin
    reset_n = 1'b0;
    sck     = 1'b0;
    sdi     = 1'b0;
    cs_n    = 3'b111;
    clk_wait(3);
    chk("rst_tx_ready", bus0.tx_ready, 1);
    chk("rst_rx_valid", bus0.rx_valid, 0);
    chk("rst_rx_data",  bus0.rx_data, 0);
    chk("rst_sdo",      {sd0, sd1, sd2}, 0);
    chk("rst_oe",       {oe0, oe1, oe2}, 0);
    chk("rst_strobes",  {st0, sp0, ur0, st2, sp2, ur2}, 0);
    reset_n = 1'b1;

    // Mode 0: preloaded hold 0xA5 out, 0x3C in.
    use_dut(0);
    push(0, 16'hA5);
    clk_wait(4);
    chk("t1_hold_full", bus0.tx_ready, 0);
    b_rx = rxc[0]; b_st = stc[0]; b_sp = spc[0];
    cs_assert();
    chk("t1_oe_active", oe0, 1);
    xfer(16'h3C, 8, m);
    cs_release();
    chk("t1_sdo_word", m, 16'hA5);
    chk("t1_rx_count", rxc[0] - b_rx, 1);
    chk("t1_rx_data",  rxd[0], 16'h3C);
    chk("t1_start",    stc[0] - b_st, 1);
    chk("t1_stop",     spc[0] - b_sp, 1);
    chk("t1_oe_idle",  oe0, 0);

    // Mode 3: three-word frame fed through valid/ready.
    use_dut(2);
    push(2, 16'h01); push(2, 16'h02); push(2, 16'h03);
    b_rx = rxc[2];
    cs_assert();
    xfer(16'h11, 8, m);
    chk("t2_sdo_w0", m, 16'h01);
    chk("t2_rx_w0",  rxd[2], 16'h11);
    xfer(16'h22, 8, m);
    chk("t2_sdo_w1", m, 16'h02);
    chk("t2_rx_w1",  rxd[2], 16'h22);
    xfer(16'h33, 8, m);
    chk("t2_sdo_w2", m, 16'h03);
    chk("t2_rx_w2",  rxd[2], 16'h33);
    cs_release();
    chk("t2_rx_count", rxc[2] - b_rx, 3);
    chk("t2_underrun", ur2, 0);

    // Mode 0 underrun: no TX data, fill pattern, sticky until next start.
    use_dut(0);
    b_st = stc[0];
    cs_assert();
    chk("t3_start",        stc[0] - b_st, 1);
    chk("t3_underrun_set", ur0, 1);
    xfer(16'h00, 8, m);
    cs_release();
    chk("t3_sdo_fill",      m, 16'hFF);
    chk("t3_underrun_held", ur0, 1);
    push(0, 16'h5A);
    clk_wait(4);
    cs_assert();
    chk("t3_underrun_clr", ur0, 0);
    cs_release();

    // Abort after 5 bits; hold content survives into the next frame.
    push(0, 16'hC3); push(0, 16'h5A);
    clk_wait(4);
    b_rx = rxc[0]; b_sp = spc[0];
    cs_assert();
    xfer(16'h00, 5, m);
    cs_release();
    chk("t4_abort_rx",    rxc[0] - b_rx, 0);
    chk("t4_abort_stop",  spc[0] - b_sp, 1);
    chk("t4_abort_sdo",   m, 16'hC0);
    chk("t4_hold_kept",   bus0.tx_ready, 0);
    b_rx = rxc[0];
    cs_assert();
    xfer(16'h96, 8, m);
    cs_release();
    chk("t4_next_rx_cnt", rxc[0] - b_rx, 1);
    chk("t4_next_rx",     rxd[0], 16'h96);
    chk("t4_next_sdo",    m, 16'h5A);

    // Mode 1, 16-bit LSB first.
    use_dut(1);
    push(1, 16'hBEEF);
    clk_wait(4);
    b_rx = rxc[1];
    cs_assert();
    xfer(16'h1234, 16, m);
    cs_release();
    chk("t5_rx_count", rxc[1] - b_rx, 1);
    chk("t5_rx_data",  rxd[1], 16'h1234);
    chk("t5_sdo_word", m, 16'hBEEF);
    chk("t5_underrun", ur1, 0);

    // Reset mid-word with the holding register full.
    use_dut(0);
    push(0, 16'h11); push(0, 16'h22);
    clk_wait(4);
    cs_assert();
    clk_wait(4);
    xfer(16'h00, 3, m);
    chk("t6_hold_full", bus0.tx_ready, 0);
    b_st = stc[0]; b_sp = spc[0]; b_rx = rxc[0];
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ready",   bus0.tx_ready, 1);
    chk("t6_rst_pins",    {sd0, oe0}, 0);
    chk("t6_rst_strobes", {st0, sp0, ur0, bus0.rx_valid}, 0);
    chk("t6_rst_rx_data", bus0.rx_data, 0);
    cs_n[0] = 1'b1;
    sck = 1'b0;
    clk_wait(4);
    reset_n = 1'b1;
    clk_wait(10);
    chk("t6_no_strobes", (stc[0] - b_st) + (spc[0] - b_sp) + (rxc[0] - b_rx), 0);
    chk("t6_idle_oe",    oe0, 0);
    push(0, 16'h4B);
    clk_wait(4);
    b_st = stc[0]; b_rx = rxc[0];
    cs_assert();
    xfer(16'hE1, 8, m);
    cs_release();
    chk("t6_start",    stc[0] - b_st, 1);
    chk("t6_rx_count", rxc[0] - b_rx, 1);
    chk("t6_rx_data",  rxd[0], 16'hE1);
    chk("t6_sdo_word", m, 16'h4B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
